// File: rtl/conv_decoder_bs.sv
// conv_decoder_bs: hard-decision Viterbi decoder for the tail-biting K=7,
// rate-1/3 code (generators 133/171/165 octal). There are 64 ACS lanes, one
// trellis step per cycle, and register-exchange survivors of depth TB_LEN.
// Optional feature: define CONVDEC_METRIC_EN to add the final_metric output.
// State index: bit 5 = s1 (most recent input) ... bit 0 = s6 (oldest input).

// One ACS lane for next state STATE. Its predecessors are {STATE[4:0], s6}.
module conv_decoder_bs_acs #(
  parameter int STATE    = 0,
  parameter int METRIC_W = 8,
  parameter int TB_LEN   = 32
) (
  input  logic [2:0]          rx,
  input  logic [METRIC_W-1:0] m0,
  input  logic [METRIC_W-1:0] m1,
  input  logic [TB_LEN-2:0]   h0,
  input  logic [TB_LEN-2:0]   h1,
  output logic [METRIC_W-1:0] nm,
  output logic [TB_LEN-1:0]   nh
);
  localparam logic [5:0] NXT = 6'(STATE);

  // Branch label {d2,d1,d0} leaving predecessor p on input u.
  function automatic logic [2:0] label(input logic [5:0] p, input logic u);
    return {u ^ p[5] ^ p[4] ^ p[2] ^ p[0],
            u ^ p[5] ^ p[4] ^ p[3] ^ p[0],
            u ^ p[4] ^ p[3] ^ p[1] ^ p[0]};
  endfunction

  function automatic logic [METRIC_W-1:0] hd(input logic [2:0] x);
    return METRIC_W'(x[0]) + METRIC_W'(x[1]) + METRIC_W'(x[2]);
  endfunction

  logic [METRIC_W-1:0] pm0, pm1;

  // Add-compare-select. On a tie, the predecessor with s6=0 wins.
  always_comb begin
    pm0 = m0 + hd(rx ^ label({NXT[4:0], 1'b0}, NXT[5]));
    pm1 = m1 + hd(rx ^ label({NXT[4:0], 1'b1}, NXT[5]));
    if (pm0 <= pm1) begin
      nm = pm0;
      nh = {h0, NXT[5]};
    end else begin
      nm = pm1;
      nh = {h1, NXT[5]};
    end
  end
endmodule

module conv_decoder_bs #(
  parameter int TB_LEN   = 32,
  parameter int METRIC_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        code_block_length,
  input  logic        sym_valid,
  output logic        sym_ready,
  input  logic [7:0]  sym0,
  input  logic [7:0]  sym1,
  input  logic [7:0]  sym2,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [7:0]  dec_data,
  output logic        dec_last,
  output logic        busy,
  output logic        done
`ifdef CONVDEC_METRIC_EN
  ,
  output logic [15:0] final_metric
`endif
);
  localparam int NS = 64;
  localparam logic [12:0] TB_C  = 13'(TB_LEN);
  localparam logic [6:0]  FL_LAST = 7'(TB_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;
  state_t state_q, state_d;

  logic [12:0] n_q, step_q;
  logic [3:0]  sym_cnt_q;
  logic [7:0]  sh0_q, sh1_q, sh2_q;
  logic [6:0]  flush_cnt_q;
  logic [6:0]  pack_q;
  logic [2:0]  bit_cnt_q;
  logic [NS-1:0][METRIC_W-1:0] metric_q, acs_m, acs_n;
  logic [NS-1:0][TB_LEN-1:0]   hist_q, acs_h;
  logic [5:0]          best_idx;
  logic [METRIC_W-1:0] best_m;
  logic [TB_LEN-1:0]   best_hist;
  logic all_msb, fbit, out_stall, step_act, emit_req, blocked;
  logic step_en, flush_en, emit, last_step, last_flush, sym_acc;

  for (genvar g = 0; g < NS; g++) begin : g_lane
    conv_decoder_bs_acs #(.STATE(g), .METRIC_W(METRIC_W), .TB_LEN(TB_LEN)) u_acs (
      .rx ({sh2_q[0], sh1_q[0], sh0_q[0]}),
      .m0 (metric_q[(g % 32) * 2]),
      .m1 (metric_q[(g % 32) * 2 + 1]),
      .h0 (hist_q[(g % 32) * 2][TB_LEN-2:0]),
      .h1 (hist_q[(g % 32) * 2 + 1][TB_LEN-2:0]),
      .nm (acs_m[g]),
      .nh (acs_h[g])
    );
  end

  // Normalise: once every metric has its MSB set, drop that bit everywhere.
  always_comb begin
    all_msb = 1'b1;
    for (int i = 0; i < NS; i++) all_msb = all_msb & acs_m[i][METRIC_W-1];
    acs_n = acs_m;
    if (all_msb)
      for (int i = 0; i < NS; i++) acs_n[i][METRIC_W-1] = 1'b0;
  end

  // Find the minimum-metric state; on a tie the lowest index wins.
  always_comb begin
    best_idx = '0;
    best_m   = metric_q[0];
    for (int i = 1; i < NS; i++)
      if (metric_q[i] < best_m) begin
        best_m   = metric_q[i];
        best_idx = 6'(i);
      end
    best_hist = hist_q[best_idx];
  end

  // Select the output bit: history bit TB_LEN-1-flush_cnt. flush_cnt stays 0
  // during RUN, so this also gives the RUN decision bit.
  always_comb begin
    fbit = 1'b0;
    for (int i = 0; i < TB_LEN; i++)
      if (7'(i) == flush_cnt_q) fbit = best_hist[TB_LEN-1-i];
  end

  // Datapath enables. A bit that completes a byte must wait for the output slot.
  always_comb begin
    out_stall  = dec_valid && !dec_ready;
    step_act   = (state_q == RUN) && (sym_cnt_q != 4'd0);
    emit_req   = (step_act && step_q >= TB_C) || (state_q == FLUSH);
    blocked    = emit_req && (bit_cnt_q == 3'd7) && out_stall;
    step_en    = step_act && !blocked;
    flush_en   = (state_q == FLUSH) && !blocked;
    emit       = emit_req && !blocked;
    last_step  = step_en && (step_q == n_q - 13'd1);
    last_flush = flush_en && (flush_cnt_q == FL_LAST);
    sym_acc    = sym_valid && sym_ready;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)      state_d = RUN;
      RUN:     if (last_step)  state_d = FLUSH;
      FLUSH:   if (last_flush) state_d = DRAIN;
      DRAIN:   if (dec_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy      = (state_q != IDLE);
    sym_ready = (state_q == RUN) && (sym_cnt_q == 4'd0) && !out_stall;
  end

  // Trellis state: block setup, symbol intake, one ACS step per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_q <= '0; step_q <= '0; sym_cnt_q <= '0; flush_cnt_q <= '0;
      sh0_q <= '0; sh1_q <= '0; sh2_q <= '0;
      metric_q <= '0; hist_q <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        n_q         <= code_block_length ? 13'd6144 : 13'd1056;
        step_q      <= '0;
        flush_cnt_q <= '0;
        sym_cnt_q   <= '0;
        metric_q    <= '0;
        hist_q      <= '0;
      end
      if (sym_acc) begin
        sh0_q <= sym0; sh1_q <= sym1; sh2_q <= sym2;
        sym_cnt_q <= 4'd8;
      end
      if (step_en) begin
        metric_q  <= acs_n;
        hist_q    <= acs_h;
        step_q    <= step_q + 13'd1;
        sym_cnt_q <= sym_cnt_q - 4'd1;
        sh0_q <= sh0_q >> 1; sh1_q <= sh1_q >> 1; sh2_q <= sh2_q >> 1;
      end
      if (flush_en) flush_cnt_q <= flush_cnt_q + 7'd1;
    end
  end

  // Output packer: LSB-first bytes, final-byte tag, and the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      dec_valid <= 1'b0; dec_data <= '0; dec_last <= 1'b0; done <= 1'b0;
      pack_q <= '0; bit_cnt_q <= '0;
    end else begin
      done <= 1'b0;
      if (dec_valid && dec_ready) begin
        dec_valid <= 1'b0;
        dec_last  <= 1'b0;
      end
      if (state_q == IDLE && start) bit_cnt_q <= '0;
      if (emit) begin
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          dec_data  <= {fbit, pack_q};
          dec_valid <= 1'b1;
          dec_last  <= last_flush;
        end else begin
          pack_q[bit_cnt_q] <= fbit;
        end
      end
      if (state_q == DRAIN && dec_ready) done <= 1'b1;
    end
  end

`ifdef CONVDEC_METRIC_EN
  logic [15:0] norm_cnt_q;

  // Count normalisation events so the true path metric can be rebuilt.
  always_ff @(posedge clk) begin
    if (reset)                           norm_cnt_q <= '0;
    else if (state_q == IDLE && start)   norm_cnt_q <= '0;
    else if (step_en && all_msb)         norm_cnt_q <= norm_cnt_q + 16'd1;
  end

  assign final_metric = (norm_cnt_q << (METRIC_W - 1)) + 16'(best_m);
`endif
endmodule

// File: tb/tb_conv_decoder_bs.sv
// Bench for conv_decoder_bs. The model is a tail-biting encoder for the
// information block; the expected decoder output is the information itself.
// Build with +define+CONVDEC_METRIC_EN to also check final_metric.
module tb_conv_decoder_bs;
  logic clk = 1'b0;
  logic reset, start, code_block_length, sym_valid, sym_ready;
  logic [7:0] sym0, sym1, sym2, dec_data;
  logic dec_valid, dec_ready, dec_last, busy, done;
`ifdef CONVDEC_METRIC_EN
  logic [15:0] final_metric;
`endif

  conv_decoder_bs dut (
    .clk(clk), .reset(reset), .start(start), .code_block_length(code_block_length),
    .sym_valid(sym_valid), .sym_ready(sym_ready),
    .sym0(sym0), .sym1(sym1), .sym2(sym2),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_data(dec_data),
    .dec_last(dec_last), .busy(busy), .done(done)
`ifdef CONVDEC_METRIC_EN
    , .final_metric(final_metric)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  bit ib [6144];
  logic [7:0] c0 [768], c1 [768], c2 [768];
  logic [7:0] exp_q [$];
  bit mon_on = 0, expect_done = 0, blk_done = 0, rnd_ready = 0;
  int mon_nb = 0, out_cnt = 0, sym_hs = 0;
  logic [7:0] first_byte;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Tail-biting encoder: the start state is the last six information bits.
  task automatic encode(input int nbits);
    bit [5:0] s;   // s[0]=s1 (most recent) .. s[5]=s6
    bit u, d0, d1, d2;
    for (int j = 0; j < 6; j++) s[j] = ib[nbits-1-j];
    for (int k = 0; k < nbits; k++) begin
      u  = ib[k];
      d0 = u ^ s[1] ^ s[2] ^ s[4] ^ s[5];
      d1 = u ^ s[0] ^ s[1] ^ s[2] ^ s[5];
      d2 = u ^ s[0] ^ s[1] ^ s[3] ^ s[5];
      c0[k/8][k%8] = d0; c1[k/8][k%8] = d1; c2[k/8][k%8] = d2;
      s = {s[4:0], u};
    end
  endtask

  task automatic fill(input int mode);   // 0 zeros, 1 impulse at bit 0, 2 random
    for (int k = 0; k < 6144; k++) ib[k] = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    if (mode == 1) ib[0] = 1'b1;
  endtask

  // Output slot: random 50% back-pressure or always ready.
  initial begin
    dec_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      dec_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Compare process: every output handshake against the scoreboard, plus done timing.
  always @(negedge clk) begin
    if (mon_on) begin
      if (sym_valid && sym_ready) sym_hs++;
      if (expect_done) begin
        chk("done_pulse", done, 1'b1);
        chk("busy_at_done", busy, 1'b0);
        expect_done = 0;
        blk_done = 1;
      end else if (!blk_done) begin
        chk("done_early", done, 1'b0);
      end
      if (dec_valid && dec_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_byte", out_cnt, mon_nb - 1);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (out_cnt == 0) first_byte = dec_data;
          chk($sformatf("dec_data[%0d]", out_cnt), dec_data, e);
          chk($sformatf("dec_last[%0d]", out_cnt), dec_last, (out_cnt == mon_nb - 1));
          out_cnt++;
          if (out_cnt == mon_nb) expect_done = 1;
        end
      end
    end
  end

  // Run one block. stop_at >= 0 abandons it with reset after that many triples.
  task automatic run_block(input bit len, input bit rnd, input bit gaps,
                           input bit extra, input int stop_at);
    int nb, t, g;
    bit hs, abort;
    logic [7:0] v;
    nb = len ? 768 : 132;
    abort = 0;
    exp_q.delete();
    for (int i = 0; i < nb; i++) begin
      for (int j = 0; j < 8; j++) v[j] = ib[8*i+j];
      exp_q.push_back(v);
    end
    mon_nb = nb; out_cnt = 0; sym_hs = 0; blk_done = 0; expect_done = 0;
    mon_on = 1; rnd_ready = rnd; sym_valid = 1'b0;
    start = 1'b1; code_block_length = len;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk); chk("busy_after_start", busy, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < nb && !abort; i++) begin
      if (i == stop_at) break;
      if (gaps) begin
        g = $urandom_range(0, 2);
        repeat (g) begin @(posedge clk); #1; end
      end
      sym_valid = 1'b1; sym0 = c0[i]; sym1 = c1[i]; sym2 = c2[i];
      if (extra && i == 20) begin start = 1'b1; code_block_length = ~len; end
      hs = 0; t = 0;
      while (!hs && t < 300) begin
        @(negedge clk); hs = sym_ready;
        @(posedge clk); #1; start = 1'b0; t++;
      end
      if (!hs) begin chk("sym_accept_timeout", 0, 1); abort = 1; end
      sym_valid = 1'b0;
    end
    if (stop_at >= 0) begin
      mon_on = 0; rnd_ready = 0;
      reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
      @(negedge clk);
      chk("rst_mid_dec_valid", dec_valid, 1'b0);
      chk("rst_mid_busy", busy, 1'b0);
      chk("rst_mid_sym_ready", sym_ready, 1'b0);
      chk("rst_mid_dec_last", dec_last, 1'b0);
      @(posedge clk); #1;
      return;
    end
    t = 0;
    while (!blk_done && t < 3000) begin @(posedge clk); t++; end
    if (!blk_done) chk("done_timeout", 0, 1);
    chk("byte_count", out_cnt, nb);
    chk("sym_handshakes", sym_hs, nb);
    mon_on = 0; rnd_ready = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; code_block_length = 1'b0; sym_valid = 1'b0;
    sym0 = '0; sym1 = '0; sym2 = '0;
    repeat (3) @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("rst_sym_ready", sym_ready, 1'b0);
    chk("rst_dec_valid", dec_valid, 1'b0);
    chk("rst_dec_last", dec_last, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dec_data", dec_data, 8'h00);
    // Symbols offered while idle must not be taken.
    @(posedge clk); #1; sym_valid = 1'b1;
    @(negedge clk); chk("idle_sym_ready", sym_ready, 1'b0);
    @(posedge clk); #1; sym_valid = 1'b0;

    // Pin the encoder with the hand-derived impulse response 133/171/165.
    fill(1); encode(1056);
    chk("enc_impulse_d0", c0[0], 8'h6D);
    chk("enc_impulse_d1", c1[0], 8'h4F);
    chk("enc_impulse_d2", c2[0], 8'h57);
    chk("enc_impulse_d0_b1", c0[1], 8'h00);
    run_block(0, 0, 0, 0, -1);
    chk("impulse_first_byte", first_byte, 8'h01);

    // All-zero block.
    fill(0); encode(1056);
    chk("enc_zero", c2[77], 8'h00);
    run_block(0, 0, 0, 0, -1);
`ifdef CONVDEC_METRIC_EN
    chk("metric_zero", final_metric, 16'd0);
`endif

    // Random block, noiseless, then with three channel bit errors.
    fill(2); encode(1056);
    run_block(0, 0, 0, 0, -1);
`ifdef CONVDEC_METRIC_EN
    chk("metric_clean", final_metric, 16'd0);
`endif
    c1[10] = c1[10] ^ 8'h08; c1[50] = c1[50] ^ 8'h10; c1[100] = c1[100] ^ 8'h01;
    run_block(0, 0, 0, 0, -1);
`ifdef CONVDEC_METRIC_EN
    chk("metric_3err", final_metric, 16'd3);
`endif

    // Long block with output back-pressure and input gaps.
    fill(2); encode(6144);
    run_block(1, 1, 1, 0, -1);
`ifdef CONVDEC_METRIC_EN
    chk("metric_long", final_metric, 16'd0);
`endif

    // A start pulse and a length change mid-block are ignored.
    fill(2); encode(1056);
    run_block(0, 0, 0, 1, -1);

    // Reset in mid-block, then a fresh block decodes cleanly.
    fill(2); encode(1056);
    run_block(0, 0, 0, 0, 40);
    fill(2); encode(1056);
    run_block(0, 0, 1, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end
endmodule

// File: doc/conv_decoder_bs.md
Name: conv_decoder_bs

Overview:
- Hard-decision Viterbi decoder for the tail-biting K=7, rate-1/3 convolutional code produced by the block encoder.
- Consumes the three coded sub-block byte streams (d0/d1/d2) and emits recovered information bytes.
- 64-state ACS array runs in parallel, one trellis step per cycle; survivors use register exchange with fixed depth TB_LEN.
- Sits at the far end of the sub-block FIFOs in the receive datapath.

Parameters:
- TB_LEN, 32: register-exchange path depth in bits, i.e. decision latency. Legal range 16..64.
- METRIC_W, 8: path-metric width in bits; modulo-normalised.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  pulse; begins a block when busy=0
- code_block_length  in  1  sampled at start; 0 -> N=1056 bits (132 bytes), 1 -> N=6144 bits (768 bytes)
- sym_valid  in  1  sym0/1/2 hold one coded byte each
- sym_ready  out  1  decoder accepts the symbol bytes this cycle
- sym0, sym1, sym2  in  8 each  coded bytes for d0, d1, d2; bit 0 = earliest step
- dec_valid  out  1  dec_data valid
- dec_ready  in  1  downstream accepts dec_data
- dec_data  out  8  decoded bits; bit 0 = earliest
- dec_last  out  1  qualifies the final byte of the block
- busy  out  1  block in progress
- done  out  1  one-cycle pulse after the final byte handshakes

Behaviour:
- Code definition:
  - State s = {s1..s6}, the previous six input bits, s1 most recent. Input u.
  - d0 = u^s2^s3^s5^s6; d1 = u^s1^s2^s3^s6; d2 = u^s1^s2^s4^s6.
  - Next state = {u, s1..s5}.
- Reset: FSM=IDLE; sym_ready=0, dec_valid=0, dec_last=0, done=0, busy=0, dec_data=0; all metrics=0; histories cleared.
- FSM states IDLE -> RUN -> FLUSH -> DRAIN -> IDLE.
- IDLE:
  - start -> latch N, zero all 64 metrics (initial state unknown, tail-biting), clear step counter; go to RUN.
  - start while busy is ignored.
- RUN:
  - sym_ready=1 only when the 8-step symbol register is empty and the output byte register is not stalled.
  - An accepted byte triple is decoded over 8 cycles, LSB first.
- Per step:
  - Branch metric = Hamming distance (0..3) between received (d0,d1,d2) and the branch label.
  - For each next state, add-compare-select over its two predecessors. Ties pick the predecessor with s6=0.
  - History[next] = {History[pred][TB_LEN-2:0], u}.
- Normalisation: if every metric has bit METRIC_W-1 set, clear that bit in all metrics the same cycle.
- Output bit:
  - For steps k >= TB_LEN, emit history bit TB_LEN-1 of the minimum-metric state; lowest index wins ties.
  - That bit is information bit k-TB_LEN.
  - Bits pack LSB-first into a byte; dec_valid rises when 8 are collected.
- Stall: if dec_valid=1 and dec_ready=0 when the next byte would complete, trellis stepping freezes. Metrics, histories and counters hold.
- After step N-1 -> FLUSH:
  - Freeze the min-metric state's history.
  - Shift out its remaining TB_LEN bits oldest-first, one per cycle, into the packer (same stall rule).
- DRAIN: hold the final byte with dec_last=1 until dec_ready. Then pulse done, drop busy, return to IDLE.
- Totals: exactly N/8 output bytes; exactly N/8 symbol-triple handshakes.
- busy=1 from the cycle after start until the cycle done pulses.
- Reset mid-block: abandon immediately; all outputs return to reset values next cycle; no partial dec_last.
- sym_valid while not in RUN: no handshake (sym_ready=0).

Optional Feature:
- Macro CONVDEC_METRIC_EN.
- Defined:
  - Adds output port final_metric (16 bits).
  - Valid from FLUSH entry until the next start.
  - Value = winning state's true accumulated metric, i.e. the number of channel bit errors on the ML path. Normalisation events count +2^(METRIC_W-1) each.
- Undefined: port and normalisation-event counter absent; decoding behaviour identical.

Test Plan:
- Length 0, all-zero symbols, dec_ready=1 -> 132 bytes of 0x00; dec_last on byte 131; done 1 cycle later; METRIC_EN: final_metric=0.
- Length 0, random information block encoded by the team's encoder (tail = last 6 bits), noiseless -> 132 bytes bit-exact; METRIC_EN: final_metric=0.
- Same block with one flipped bit in each of bytes 10, 50, 100 of sym1 -> decoded bytes bit-exact; METRIC_EN: final_metric=3.
- Length 1 random block; dec_ready toggled randomly at 50%; sym_valid gaps -> 768 bytes bit-exact, 768 sym handshakes, no bytes lost or duplicated.
- Reset asserted mid-RUN at byte 40 -> dec_valid=0, busy=0, sym_ready=0 next cycle; a new start then decodes a fresh block correctly.
- start pulsed again while busy -> ignored; byte count still 132; code_block_length changes mid-block have no effect.
